snake_logic: RTL
================

SNAKE_LOGIC -- requirements
Module: snake_logic

Interface
REQ-001 Parameters: MAX_LEN, default 16, maximum snake length in segments; INIT_LEN, default 3, length after init; START_FOOD, default 29, initial food cell index.
REQ-002 Ports; the single clock is clka and the reset is restart_n, asynchronous, active-low.
- clka  input  1  sole clock; all state updates on the rising edge.
- restart_n  input  1  asynchronous active-low reset.
- to_logic  input  2  bit 0 LOGIC_TICK, bit 1 NO_UPDATE, from the controller.
- direction_state  input  2  UP=0, DOWN=1, LEFT=2, RIGHT=3.
- game_state  input  2  INIT=0, RUN=1, STOP=2.
- prng_value  input  6  candidate food cell, valid with prng_ack.
- prng_ack  input  1  one-cycle pulse; prng_value valid.
- prng_req  output  1  level request for a new random cell.
- from_logic  output  2  bit 0 LOGIC_DONE, bit 1 GAME_END, to the controller.
- led_array_flat  output  64  bit row*8+col is lit; row 0 is the bottom row, col 0 is the left column.

Function
REQ-003 Cell index SHALL be 6 bits, {row[2:0], col[2:0]}; UP increments row, DOWN decrements row, RIGHT increments col, LEFT decrements col; the board SHALL wrap mod 8 on both axes.
REQ-004 The body SHALL be a MAX_LEN-entry circular buffer of cell indices with 4-bit head and tail pointers that wrap; a 64-bit occupancy bitmap SHALL mirror the buffer contents.
REQ-005 Tick detection SHALL use a rising-edge detect of to_logic[0]; a tick held high for N cycles SHALL count once.
REQ-006 FSM states SHALL be IDLE, MOVE, UPDATE, FOOD_REQ, FOOD_CHK and DONE.
REQ-007 IDLE with game_state==INIT SHALL hold the initial board:
- segments at cells 24, 25, 26, head at 26;
- food at START_FOOD;
- GAME_END=0, blink flag=0, LOGIC_DONE=0.
REQ-008 A tick with NO_UPDATE=1 SHALL toggle the blink flag only, with no movement, and go directly to DONE.
REQ-009 A tick with NO_UPDATE=0 and game_state==RUN SHALL go to MOVE, which computes new_head from the head and direction_state.
REQ-010 A tick in any other condition SHALL go directly to DONE with the board unchanged.
REQ-011 Collision SHALL be true when occ[new_head]=1 and the move is not a plain tail-chase.
- A plain tail-chase is new_head equal to the tail cell while not eating.
- On collision, UPDATE SHALL set GAME_END, leave the board unchanged, and go to DONE.
REQ-012 Non-eating move: UPDATE SHALL push new_head, pop the tail, clear occ[tail], set occ[new_head], then go to DONE.
REQ-013 Eating move (new_head==food):
- UPDATE SHALL push new_head without popping while length<MAX_LEN.
- At MAX_LEN it SHALL pop the tail; the length saturates.
- It SHALL then go to FOOD_REQ.
REQ-014 FOOD_REQ SHALL hold prng_req=1 until prng_ack; prng_req SHALL drop in the cycle after ack, and the FSM SHALL go to FOOD_CHK with the sampled value.
REQ-015 FOOD_CHK SHALL accept an unoccupied value as the new food and go to DONE; an occupied value SHALL return to FOOD_REQ for a retry.
REQ-016 Latency: for a non-eating or colliding move, LOGIC_DONE SHALL rise on the 3rd rising edge after the edge that samples the tick.
REQ-017 DONE SHALL hold LOGIC_DONE=1 until the next detected tick; LOGIC_DONE SHALL clear on the tick-detect edge.
REQ-018 led_array_flat SHALL equal occ OR food bit, with the head bit forced to 0 while the blink flag is 1; it SHALL be registered and update with the DONE entry.
REQ-019 GAME_END SHALL be sticky until reset or until game_state==INIT is seen in IDLE.
REQ-020 A tick arriving in any state other than IDLE/DONE SHALL be ignored.
REQ-021 game_state==INIT while in FOOD_REQ SHALL abandon the request: prng_req drops and the FSM returns to IDLE.

Reset
REQ-022 restart_n=0 SHALL asynchronously force:
- FSM=IDLE, prng_req=0, from_logic=0;
- pointers, length and occupancy to the REQ-007 board, with food=START_FOOD and blink=0;
- led_array_flat = bits 24, 25, 26, 29 set.
REQ-023 Reset asserted mid-operation SHALL abandon any PRNG handshake; no state is retained.

Structure
REQ-024 Shared package snake_pkg SHALL hold the direction, game-state and execution-state encodings, the to_logic/from_logic bit indices, and the cell-index width.
REQ-025 The circular buffer SHALL be the sub-module snake_body_fifo (push, pop, head/tail read, length, full).

Verification
REQ-026 Reset, then game_state=RUN, RIGHT tick -> LOGIC_DONE at edge 3; led bits 25, 26, 27, 29 set.
REQ-027 Head at 28, RIGHT tick (eats 29), prng_value 26 then 40 on successive acks -> two requests; food=40; length 4; LOGIC_DONE after the second ack.
REQ-028 Head at 31, RIGHT tick -> head wraps to 24; LOGIC_DONE=1; GAME_END=0.
REQ-029 Snake in a U shape, move into its own body -> GAME_END=1; led unchanged; GAME_END stays 1 through 3 NO_UPDATE ticks while the head bit toggles 0,1,0.
REQ-030 Tick held high 5 cycles -> exactly one move. restart_n pulsed low during FOOD_REQ -> prng_req=0 immediately and the REQ-022 board is restored.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared encodings for the snake game logic: directions, game/exec states,
// controller handshake bit positions and board-cell helpers.
package snake_pkg;
  localparam int unsigned CELL_W = 6;

  localparam int unsigned TICK_BIT       = 0;
  localparam int unsigned NO_UPDATE_BIT  = 1;
  localparam int unsigned LOGIC_DONE_BIT = 0;
  localparam int unsigned GAME_END_BIT   = 1;

  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;
  typedef enum logic [1:0] {GS_INIT = 2'd0, GS_RUN = 2'd1, GS_STOP = 2'd2} game_e;
  typedef enum logic [2:0] {S_IDLE, S_MOVE, S_UPDATE, S_FOOD_REQ, S_FOOD_CHK, S_DONE} exec_e;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t INIT_CELL0 = 6'd24;

  // Cell is {row, col}; 3-bit arithmetic gives the mod-8 wrap on both axes.
  function automatic cell_t next_cell(input cell_t c, input dir_e d);
    logic [2:0] row;
    logic [2:0] col;
    row = c[5:3];
    col = c[2:0];
    case (d)
      DIR_UP:    row = row + 3'd1;
      DIR_DOWN:  row = row - 3'd1;
      DIR_LEFT:  col = col - 3'd1;
      DIR_RIGHT: col = col + 3'd1;
    endcase
    return {row, col};
  endfunction

  function automatic logic [63:0] init_occ(input int unsigned len);
    logic [63:0] occ;
    occ = '0;
    for (int unsigned i = 0; i < len; i++) occ[INIT_CELL0 + cell_t'(i)] = 1'b1;
    return occ;
  endfunction

  function automatic logic [63:0] led_map(input logic [63:0] occ, input cell_t food,
                                          input cell_t head, input logic blink);
    logic [63:0] m;
    m = occ;
    m[food] = 1'b1;
    if (blink) m[head] = 1'b0;
    return m;
  endfunction
endpackage

// File: rtl/snake_body_fifo.sv
// Circular buffer of body cells; head_cell is the newest entry, tail_cell the oldest.
module snake_body_fifo
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned INIT_LEN = 3,
  localparam int unsigned PTR_W   = $clog2(MAX_LEN),
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             push,
  input  logic             pop,
  input  cell_t            push_cell,
  output cell_t            head_cell,
  output cell_t            tail_cell,
  output logic [LEN_W-1:0] length,
  output logic             full
);
  cell_t            mem_q [MAX_LEN];
  cell_t            mem_d [MAX_LEN];
  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [PTR_W-1:0] tail_ptr_q, tail_ptr_d;
  logic [LEN_W-1:0] len_q, len_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_LEN - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    mem_d      = mem_q;
    head_ptr_d = head_ptr_q;
    tail_ptr_d = tail_ptr_q;
    len_d      = len_q;
    if (init) begin
      for (int unsigned i = 0; i < MAX_LEN; i++)
        mem_d[i] = (i < INIT_LEN) ? INIT_CELL0 + cell_t'(i) : '0;
      head_ptr_d = PTR_W'(INIT_LEN - 1);
      tail_ptr_d = '0;
      len_d      = LEN_W'(INIT_LEN);
    end else begin
      if (push) begin
        head_ptr_d        = ptr_inc(head_ptr_q);
        mem_d[head_ptr_d] = push_cell;
      end
      if (pop) tail_ptr_d = ptr_inc(tail_ptr_q);
      case ({push, pop})
        2'b10:   len_d = len_q + LEN_W'(1);
        2'b01:   len_d = len_q - LEN_W'(1);
        default: len_d = len_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MAX_LEN; i++)
        mem_q[i] <= (i < INIT_LEN) ? INIT_CELL0 + cell_t'(i) : '0;
      head_ptr_q <= PTR_W'(INIT_LEN - 1);
      tail_ptr_q <= '0;
      len_q      <= LEN_W'(INIT_LEN);
    end else begin
      mem_q      <= mem_d;
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      len_q      <= len_d;
    end
  end

  assign head_cell = mem_q[head_ptr_q];
  assign tail_cell = mem_q[tail_ptr_q];
  assign length    = len_q;
  assign full      = (len_q == LEN_W'(MAX_LEN));
endmodule

// File: rtl/snake_logic.sv
// Snake game engine: advances the body on controller ticks, detects eating and
// self-collision, fetches new food from the PRNG and drives the 8x8 LED map.
module snake_logic
  import snake_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned INIT_LEN   = 3,
  parameter int unsigned START_FOOD = 29
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic [1:0]  to_logic,
  input  logic [1:0]  direction_state,
  input  logic [1:0]  game_state,
  input  logic [5:0]  prng_value,
  input  logic        prng_ack,
  output logic        prng_req,
  output logic [1:0]  from_logic,
  output logic [63:0] led_array_flat
);
  localparam int unsigned LEN_W     = $clog2(MAX_LEN + 1);
  localparam cell_t       INIT_FOOD = cell_t'(START_FOOD);
  localparam cell_t       INIT_HEAD = INIT_CELL0 + cell_t'(INIT_LEN - 1);
  localparam logic [63:0] INIT_OCC  = init_occ(INIT_LEN);
  localparam logic [63:0] INIT_LED  = led_map(INIT_OCC, INIT_FOOD, INIT_HEAD, 1'b0);

  exec_e       state_q, state_d;
  logic        tick_prev_q, tick_prev_d;
  logic        tick_q, tick_d;
  cell_t       new_head_q, new_head_d;
  cell_t       cand_q, cand_d;
  cell_t       food_q, food_d;
  logic        blink_q, blink_d;
  logic        game_end_q, game_end_d;
  logic        logic_done_q, logic_done_d;
  logic        prng_req_q, prng_req_d;
  logic [63:0] occ_q, occ_d;
  logic [63:0] led_q, led_d;

  logic             eat;
  logic             fifo_init, fifo_push, fifo_pop, fifo_full;
  cell_t            fifo_head, fifo_tail;
  logic [LEN_W-1:0] fifo_len;
  logic             unused_len;

  snake_body_fifo #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) u_body (
    .clk       (clka),
    .rst_n     (restart_n),
    .init      (fifo_init),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .push_cell (new_head_q),
    .head_cell (fifo_head),
    .tail_cell (fifo_tail),
    .length    (fifo_len),
    .full      (fifo_full)
  );
  assign unused_len = ^fifo_len;

  // The tick edge is registered before the FSM acts on it, so a plain move
  // reports LOGIC_DONE three edges after the edge that first samples the tick.
  always_comb begin
    tick_prev_d  = to_logic[TICK_BIT];
    tick_d       = to_logic[TICK_BIT] & ~tick_prev_q;
    state_d      = state_q;
    new_head_d   = new_head_q;
    cand_d       = cand_q;
    food_d       = food_q;
    blink_d      = blink_q;
    game_end_d   = game_end_q;
    logic_done_d = logic_done_q;
    prng_req_d   = prng_req_q;
    occ_d        = occ_q;
    led_d        = led_q;
    fifo_init    = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    eat          = (new_head_q == food_q);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (tick_q) begin
          logic_done_d = 1'b0;
          if (to_logic[NO_UPDATE_BIT]) begin
            blink_d = ~blink_q;
            state_d = S_DONE;
          end else if (game_state == GS_RUN && !game_end_q) begin
            state_d = S_MOVE;
          end else begin
            state_d = S_DONE;
          end
        end else if (game_state == GS_INIT) begin
          if (state_q == S_DONE) begin
            state_d      = S_IDLE;
            logic_done_d = 1'b0;
          end else begin
            fifo_init  = 1'b1;
            occ_d      = INIT_OCC;
            food_d     = INIT_FOOD;
            blink_d    = 1'b0;
            game_end_d = 1'b0;
            led_d      = INIT_LED;
          end
        end else if (state_q == S_DONE) begin
          logic_done_d = 1'b1;
        end
      end
      S_MOVE: begin
        new_head_d = next_cell(fifo_head, dir_e'(direction_state));
        state_d    = S_UPDATE;
      end
      S_UPDATE: begin
        // Stepping onto the tail cell is legal only when the tail leaves this move.
        if (occ_q[new_head_q] && !(new_head_q == fifo_tail && !eat)) begin
          game_end_d   = 1'b1;
          logic_done_d = 1'b1;
          state_d      = S_DONE;
        end else begin
          fifo_push = 1'b1;
          fifo_pop  = !eat || fifo_full;
          if (fifo_pop) occ_d[fifo_tail] = 1'b0;
          occ_d[new_head_q] = 1'b1;
          if (eat) begin
            prng_req_d = 1'b1;
            state_d    = S_FOOD_REQ;
          end else begin
            logic_done_d = 1'b1;
            state_d      = S_DONE;
          end
        end
      end
      S_FOOD_REQ: begin
        if (game_state == GS_INIT) begin
          prng_req_d = 1'b0;
          state_d    = S_IDLE;
        end else if (prng_ack) begin
          cand_d     = prng_value;
          prng_req_d = 1'b0;
          state_d    = S_FOOD_CHK;
        end
      end
      S_FOOD_CHK: begin
        if (occ_q[cand_q]) begin
          prng_req_d = 1'b1;
          state_d    = S_FOOD_REQ;
        end else begin
          food_d       = cand_q;
          logic_done_d = 1'b1;
          state_d      = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_DONE)
      led_d = led_map(occ_d, food_d, fifo_push ? new_head_q : fifo_head, blink_d);
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q      <= S_IDLE;
      tick_prev_q  <= 1'b0;
      tick_q       <= 1'b0;
      new_head_q   <= '0;
      cand_q       <= '0;
      food_q       <= INIT_FOOD;
      blink_q      <= 1'b0;
      game_end_q   <= 1'b0;
      logic_done_q <= 1'b0;
      prng_req_q   <= 1'b0;
      occ_q        <= INIT_OCC;
      led_q        <= INIT_LED;
    end else begin
      state_q      <= state_d;
      tick_prev_q  <= tick_prev_d;
      tick_q       <= tick_d;
      new_head_q   <= new_head_d;
      cand_q       <= cand_d;
      food_q       <= food_d;
      blink_q      <= blink_d;
      game_end_q   <= game_end_d;
      logic_done_q <= logic_done_d;
      prng_req_q   <= prng_req_d;
      occ_q        <= occ_d;
      led_q        <= led_d;
    end
  end

  assign prng_req                   = prng_req_q;
  assign from_logic[LOGIC_DONE_BIT] = logic_done_q;
  assign from_logic[GAME_END_BIT]   = game_end_q;
  assign led_array_flat             = led_q;
endmodule
